// File: rtl/gate_alu_arbiter.sv
// Two-requester arbiter around one registered bitwise gate unit (IDLE -> EXEC -> RESP).
// Define GATE_ARB_FIXED_PRIO_EN for fixed req0 priority; default is round-robin.
module gate_alu_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_last_grant;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_y;
  logic [WIDTH-1:0] w_gate_y;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;

  // Grants are suppressed while reset is asserted so no ready leaks out.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == StIdle && rst_n) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
      if (req0_valid) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
`else
      if (req0_valid && req1_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else if (req0_valid) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
`endif
    end
  end

  assign w_accept = w_grant0 | w_grant1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StExec;
      StExec:  w_state_next = StResp;
      StResp:  if (rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_gate_y = '0;
    case (r_op)
      3'd0:    w_gate_y = r_a & r_b;
      3'd1:    w_gate_y = ~(r_a & r_b);
      3'd2:    w_gate_y = r_a | r_b;
      3'd3:    w_gate_y = ~(r_a | r_b);
      3'd4:    w_gate_y = r_a ^ r_b;
      3'd5:    w_gate_y = ~(r_a ^ r_b);
      3'd6:    w_gate_y = ~r_a;
      default: w_gate_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_y      <= '0;
    end else begin
      if (w_accept) begin
        r_op         <= w_grant1 ? req1_op : req0_op;
        r_a          <= w_grant1 ? req1_a  : req0_a;
        r_b          <= w_grant1 ? req1_b  : req0_b;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
      end
      if (r_state == StExec) begin
        r_rsp_y     <= w_gate_y;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == StResp && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_y      = r_rsp_y;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_gate_alu_arbiter.sv
// Directed self-checking bench for gate_alu_arbiter (WIDTH=8).
module tb_gate_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_y;

  int checks = 0;
  int errors = 0;

  gate_alu_arbiter #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op from requester id through the full handshake with rsp_ready high.
  task automatic do_op(input logic id, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_y);
    logic rdy;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    rdy = id ? req1_ready : req0_ready;
    for (int k = 0; k < 8 && !rdy; k++) begin
      step();
      rdy = id ? req1_ready : req0_ready;
    end
    check("op_ready", 32'(rdy), 32'd1);
    check("op_other_ready", 32'(id ? req0_ready : req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("op_ready_one_cycle", 32'(req0_ready | req1_ready), 32'd0);
    check("op_busy_exec", 32'(busy), 32'd1);
    check("op_no_rsp_in_exec", 32'(rsp_valid), 32'd0);
    step();
    check("op_rsp_valid", 32'(rsp_valid), 32'd1);
    check("op_rsp_y", 32'(rsp_y), 32'(exp_y));
    check("op_rsp_id", 32'(rsp_id), 32'(id));
    step();
    check("op_rsp_drop", 32'(rsp_valid), 32'd0);
    check("op_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       g;
    logic       exp_g;
    logic [7:0] hold_y;

    // Reset with every input driven high.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd7; req0_a = 8'hFF; req0_b = 8'hFF;
    req1_valid = 1'b1; req1_op = 3'd7; req1_a = 8'hFF; req1_b = 8'hFF;
    rsp_ready = 1'b1;
    step();
    step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp_y", 32'(rsp_y), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Single AND, then the remaining opcodes including NOT and reserved.
    do_op(1'b0, 3'd0, 8'hF0, 8'h3C, 8'h30);
    do_op(1'b1, 3'd6, 8'h0F, 8'hAA, 8'hF0);
    do_op(1'b0, 3'd7, 8'hFF, 8'hFF, 8'h00);
    do_op(1'b1, 3'd1, 8'hF0, 8'h3C, 8'hCF);
    do_op(1'b0, 3'd2, 8'hF0, 8'h0C, 8'hFC);
    do_op(1'b1, 3'd5, 8'hA5, 8'h0F, 8'h55);

    // Fresh reset so the first contention goes to req0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'hAA; req0_b = 8'hFF;
    req1_valid = 1'b1; req1_op = 3'd3; req1_a = 8'h0F; req1_b = 8'hF0;
    #1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8 && !(req0_ready | req1_ready); k++) step();
      check("rr_any_ready", 32'(req0_ready | req1_ready), 32'd1);
      check("rr_onehot", 32'(req0_ready & req1_ready), 32'd0);
      g = req1_ready;
`ifdef GATE_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = i[0];
`endif
      check("rr_grant", 32'(g), 32'(exp_g));
      step();
      step();
      check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rr_rsp_id", 32'(rsp_id), 32'(exp_g));
      check("rr_rsp_y", 32'(rsp_y), exp_g ? 32'h00 : 32'h55);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 4 && busy; k++) step();
    check("rr_drain", 32'(busy), 32'd0);

    // Back-pressure: response held while rsp_ready is low, no grants meanwhile.
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'hFF; req1_b = 8'h5A;
    #1;
    check("bp_accept", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'h01; req0_b = 8'h02;
    step();
    hold_y = 8'h5A;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_y", 32'(rsp_y), 32'(hold_y));
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_no_ready", 32'(req0_ready | req1_ready), 32'd0);
      step();
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_idle", 32'(busy), 32'd0);

    // Reset while in EXEC discards the op.
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 8'h11; req1_b = 8'h22;
    #1;
    check("rx_accept", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    check("rx_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("rx_no_rsp", 32'(rsp_valid), 32'd0);
      check("rx_idle", 32'(busy), 32'd0);
      step();
    end
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h0F; req0_b = 8'hFF;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'hF0; req1_b = 8'hFF;
    #1;
    check("rx_req0_first", 32'(req0_ready), 32'd1);
    check("rx_req1_wait", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
